// File: rtl/key_scan_pkg.sv
// rtl/key_scan_pkg.sv - shared types and constant helpers for the key scanner
//
// Contents:
//   key_state_e : per-channel debounce FSM state (IDLE, PDB, HELD, RDB)
//   CLOG2       : ceiling log2 for constant width calculations
//   bits_for    : register width able to hold 0..max_value, never below 1
//   ms_div      : clock cycles per 1 ms time-base tick (MS_DIV)
package key_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,    // released, waiting for the key to go active
        PDB  = 2'd1,    // press debounce
        HELD = 2'd2,    // accepted press, counting hold time
        RDB  = 2'd3     // release debounce, hold time frozen
    } key_state_e;

    function automatic int CLOG2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

    // A zero-range counter (e.g. long detection disabled) still gets one bit
    // so every vector stays legal.
    function automatic int bits_for(input int max_value);
        int w;
        w = CLOG2(max_value + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // MS_DIV: clock cycles per millisecond; the clock is a multiple of 1 kHz.
    function automatic int ms_div(input int clk_freq_hz);
        return clk_freq_hz / 1000;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// rtl/key_debounce_ch.sv - one key channel: synchroniser, debounce FSM, hold timer
//
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_ms_tick    : one-cycle strobe once per millisecond from the shared prescaler
//   i_key        : raw asynchronous key pin
//   o_level      : debounced state, 1 = pressed
//   o_press      : one-cycle pulse when a press is accepted
//   o_release    : one-cycle pulse when a release is accepted
//   o_long       : one-cycle pulse when the hold time reaches P_LONG_MS
module key_debounce_ch
    import key_scan_pkg::*;
#(
    parameter int P_DEBOUNCE_MS = 20,
    parameter int P_LONG_MS     = 1000,
    parameter bit P_KEY_ON      = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_ms_tick,
    input  logic i_key,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    localparam int DB_W   = bits_for(P_DEBOUNCE_MS);
    localparam int HOLD_W = bits_for(P_LONG_MS);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(P_DEBOUNCE_MS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(P_LONG_MS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(P_LONG_MS - 1);

    // Synchroniser idles at the released pin level so reset never looks
    // like a press.
    logic [1:0]        sync_q;
    logic              key_on;

    key_state_e        state_q,    state_d;
    logic [DB_W-1:0]   db_cnt_q,   db_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              level_q,    level_d;
    logic              press_q,    press_d;
    logic              release_q,  release_d;
    logic              long_q,     long_d;

    assign key_on = (sync_q[1] == P_KEY_ON);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q     <= {2{~P_KEY_ON}};
            state_q    <= IDLE;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], i_key};
            state_q    <= state_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
        end
    end

    // A change of key_on always wins over a coincident ms tick: the pending
    // debounce is abandoned rather than accepted.
    always_comb begin
        state_d    = state_q;
        db_cnt_d   = db_cnt_q;
        hold_cnt_d = hold_cnt_q;
        level_d    = level_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (key_on) begin
                    state_d  = PDB;
                    db_cnt_d = '0;
                end
            end

            PDB: begin
                if (!key_on) begin
                    state_d = IDLE;
                end else if (i_ms_tick) begin
                    if (db_cnt_q == DB_LAST) begin
                        state_d    = HELD;
                        press_d    = 1'b1;
                        level_d    = 1'b1;
                        hold_cnt_d = '0;
                    end else begin
                        db_cnt_d = db_cnt_q + 1'b1;
                    end
                end
            end

            HELD: begin
                if (!key_on) begin
                    state_d  = RDB;
                    db_cnt_d = '0;
                end else if (i_ms_tick && (hold_cnt_q < HOLD_MAX)) begin
                    // Saturating counter: the long pulse fires only on the
                    // increment that reaches the limit, so once per press.
                    hold_cnt_d = hold_cnt_q + 1'b1;
                    long_d     = (hold_cnt_q == HOLD_LAST);
                end
            end

            RDB: begin
                // hold_cnt_q is left untouched here, so a release bounce
                // neither restarts nor re-arms the long event.
                if (key_on) begin
                    state_d = HELD;
                end else if (i_ms_tick) begin
                    if (db_cnt_q == DB_LAST) begin
                        state_d    = IDLE;
                        release_d  = 1'b1;
                        level_d    = 1'b0;
                        hold_cnt_d = '0;
                    end else begin
                        db_cnt_d = db_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_level   = level_q;
    assign o_press   = press_q;
    assign o_release = release_q;
    assign o_long    = long_q;

endmodule

// File: rtl/key_scan.sv
// rtl/key_scan.sv - multi-key debouncer with press, release and long-press events
//
// Ports:
//   i_clk         : system clock
//   i_rst         : asynchronous active-high reset
//   i_key         : raw asynchronous key pins, P_KEY_NUM wide
//   o_key_level   : debounced key states, 1 = pressed
//   o_key_press   : one-cycle press-accepted pulses
//   o_key_release : one-cycle release-accepted pulses
//   o_key_long    : one-cycle long-press pulses
module key_scan
    import key_scan_pkg::*;
#(
    parameter int P_KEY_NUM     = 2,
    parameter int P_CLK_FREQ_HZ = 10_000_000,
    parameter int P_DEBOUNCE_MS = 20,
    parameter int P_LONG_MS     = 1000,
    parameter int P_KEY_ON      = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [P_KEY_NUM-1:0] i_key,
    output logic [P_KEY_NUM-1:0] o_key_level,
    output logic [P_KEY_NUM-1:0] o_key_press,
    output logic [P_KEY_NUM-1:0] o_key_release,
    output logic [P_KEY_NUM-1:0] o_key_long
);

    localparam int MS_DIV = ms_div(P_CLK_FREQ_HZ);
    localparam int PRE_W  = bits_for(MS_DIV - 1);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(MS_DIV - 1);

    // Free-running millisecond prescaler shared by every channel; key
    // activity never restarts it, which is why acceptance time has a
    // one-tick uncertainty.
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic             ms_tick;

    assign ms_tick = (pre_cnt_q == PRE_LAST);

    always_comb begin
        pre_cnt_d = pre_cnt_q + 1'b1;
        if (ms_tick) begin
            pre_cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

    for (genvar g = 0; g < P_KEY_NUM; g++) begin : g_ch
        key_debounce_ch #(
            .P_DEBOUNCE_MS (P_DEBOUNCE_MS),
            .P_LONG_MS     (P_LONG_MS),
            .P_KEY_ON      (P_KEY_ON != 0)
        ) u_ch (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_ms_tick (ms_tick),
            .i_key     (i_key[g]),
            .o_level   (o_key_level[g]),
            .o_press   (o_key_press[g]),
            .o_release (o_key_release[g]),
            .o_long    (o_key_long[g])
        );
    end

endmodule

// File: tb/tb_key_scan.sv
// tb/tb_key_scan.sv - self-checking bench for key_scan against a tick-counting model
module tb_key_scan;

    localparam int NK       = 2;
    localparam int CLK_HZ   = 10_000;
    localparam int DB_MS    = 3;
    localparam int LONG_MS  = 8;
    localparam int KEY_ON   = 0;
    localparam int DIV      = CLK_HZ / 1000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] key = '1;
    logic [NK-1:0] dut_level, dut_press, dut_rel, dut_long;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    key_scan #(
        .P_KEY_NUM     (NK),
        .P_CLK_FREQ_HZ (CLK_HZ),
        .P_DEBOUNCE_MS (DB_MS),
        .P_LONG_MS     (LONG_MS),
        .P_KEY_ON      (KEY_ON)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_key         (key),
        .o_key_level   (dut_level),
        .o_key_press   (dut_press),
        .o_key_release (dut_rel),
        .o_key_long    (dut_long)
    );

    // Reference: k is the pin seen two clocks late. A ms tick "counts" only
    // when k held the same value on this and the previous clock. DB_MS
    // counted ticks with k opposite to the level flip the level; counted
    // ticks while pressed and level=1 accumulate hold time up to LONG_MS.
    typedef struct packed {
        logic [7:0]      phase;
        logic [NK-1:0]   pipe0;
        logic [NK-1:0]   pipe1;
        logic [NK-1:0]   kprev;
        logic [NK-1:0]   level;
        logic [NK-1:0]   press;
        logic [NK-1:0]   rel;
        logic [NK-1:0]   lng;
        logic [NK-1:0][7:0] run;
        logic [NK-1:0][7:0] held;
    } model_t;

    model_t ms;

    function automatic model_t model_reset();
        model_t r;
        r = '0;
        r.pipe0 = '1;
        r.pipe1 = '1;
        return r;
    endfunction

    function automatic model_t model_next(input model_t m, input logic [NK-1:0] pin);
        model_t n;
        logic   tick;
        logic   k;
        n = m;
        tick = (int'(m.phase) == DIV - 1);
        n.phase = tick ? 8'd0 : m.phase + 8'd1;
        n.press = '0;
        n.rel   = '0;
        n.lng   = '0;
        for (int i = 0; i < NK; i++) begin
            k = (int'(m.pipe1[i]) == KEY_ON);
            if (k != m.kprev[i]) begin
                n.run[i] = 8'd0;
            end else if (tick) begin
                if (k != m.level[i]) begin
                    n.run[i] = m.run[i] + 8'd1;
                    if (int'(n.run[i]) == DB_MS) begin
                        n.level[i] = k;
                        n.run[i]   = 8'd0;
                        n.held[i]  = 8'd0;
                        if (k) n.press[i] = 1'b1;
                        else   n.rel[i]   = 1'b1;
                    end
                end else if (k && int'(m.held[i]) < LONG_MS) begin
                    n.held[i] = m.held[i] + 8'd1;
                    if (int'(n.held[i]) == LONG_MS) n.lng[i] = 1'b1;
                end
            end
            n.kprev[i] = k;
        end
        n.pipe1 = m.pipe0;
        n.pipe0 = pin;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) ms <= model_reset();
        else     ms <= model_next(ms, key);
    end

    task automatic test_reset();
        rst = 1'b1;
        key = 2'b11;
        repeat (4) @(negedge clk);
        checks++; if (dut_level !== 2'b00) begin errors++; $display("FAIL reset_level: got %b want 00", dut_level); end
        checks++; if (dut_press !== 2'b00) begin errors++; $display("FAIL reset_press: got %b want 00", dut_press); end
        checks++; if (dut_rel   !== 2'b00) begin errors++; $display("FAIL reset_release: got %b want 00", dut_rel); end
        checks++; if (dut_long  !== 2'b00) begin errors++; $display("FAIL reset_long: got %b want 00", dut_long); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_clean_press();
        int drive_cyc, press_cyc, rel_cyc, n_press, n_rel;
        n_press = 0; n_rel = 0; press_cyc = 0; rel_cyc = 0;
        key[0] = 1'b0;
        drive_cyc = cyc;
        repeat (100) begin
            @(negedge clk);
            checks++;
            if ({dut_level, dut_press, dut_rel, dut_long} !== {ms.level, ms.press, ms.rel, ms.lng}) begin
                errors++; $display("FAIL clean_model: dut=%b model=%b", {dut_level, dut_press, dut_rel, dut_long}, {ms.level, ms.press, ms.rel, ms.lng});
            end
            if (dut_press[0]) begin n_press++; press_cyc = cyc; end
        end
        checks++; if (n_press != 1) begin errors++; $display("FAIL clean_press_count: got %0d want 1", n_press); end
        checks++; if ((press_cyc - (drive_cyc + 2)) < 20 || (press_cyc - (drive_cyc + 2)) > 31) begin
            errors++; $display("FAIL clean_press_delay: got %0d want 20..31", press_cyc - (drive_cyc + 2));
        end
        checks++; if (dut_level[0] !== 1'b1) begin errors++; $display("FAIL clean_level_high: got %b want 1", dut_level[0]); end

        key[0] = 1'b1;
        drive_cyc = cyc;
        repeat (100) begin
            @(negedge clk);
            checks++;
            if ({dut_level, dut_press, dut_rel, dut_long} !== {ms.level, ms.press, ms.rel, ms.lng}) begin
                errors++; $display("FAIL clean_rel_model: dut=%b model=%b", {dut_level, dut_press, dut_rel, dut_long}, {ms.level, ms.press, ms.rel, ms.lng});
            end
            if (dut_rel[0]) begin n_rel++; rel_cyc = cyc; end
        end
        checks++; if (n_rel != 1) begin errors++; $display("FAIL clean_release_count: got %0d want 1", n_rel); end
        checks++; if ((rel_cyc - (drive_cyc + 2)) < 20 || (rel_cyc - (drive_cyc + 2)) > 31) begin
            errors++; $display("FAIL clean_release_delay: got %0d want 20..31", rel_cyc - (drive_cyc + 2));
        end
        checks++; if (dut_level[0] !== 1'b0) begin errors++; $display("FAIL clean_level_low: got %b want 0", dut_level[0]); end
    endtask

    task automatic test_bounce();
        int n_bad;
        n_bad = 0;
        for (int c = 0; c < 240; c++) begin
            if (c < 200 && (c % 7) == 0) key[0] = ~key[0];
            if (c == 200) key[0] = 1'b1;
            @(negedge clk);
            checks++;
            if ({dut_level, dut_press, dut_rel, dut_long} !== {ms.level, ms.press, ms.rel, ms.lng}) begin
                errors++; $display("FAIL bounce_model: dut=%b model=%b", {dut_level, dut_press, dut_rel, dut_long}, {ms.level, ms.press, ms.rel, ms.lng});
            end
            if ((dut_level | dut_press | dut_rel | dut_long) !== 2'b00) n_bad++;
        end
        checks++; if (n_bad != 0) begin errors++; $display("FAIL bounce_quiet: got %0d active cycles want 0", n_bad); end
    endtask

    task automatic test_long_press();
        int press_cyc, long_cyc, n_press, n_long, n_rel;
        n_press = 0; n_long = 0; n_rel = 0; press_cyc = 0; long_cyc = 0;
        key[1] = 1'b0;
        for (int c = 0; c < 260; c++) begin
            if (c == 200) key[1] = 1'b1;
            @(negedge clk);
            checks++;
            if ({dut_level, dut_press, dut_rel, dut_long} !== {ms.level, ms.press, ms.rel, ms.lng}) begin
                errors++; $display("FAIL long_model: dut=%b model=%b", {dut_level, dut_press, dut_rel, dut_long}, {ms.level, ms.press, ms.rel, ms.lng});
            end
            if (dut_press[1]) begin n_press++; press_cyc = cyc; end
            if (dut_long[1])  begin n_long++;  long_cyc  = cyc; end
            if (dut_rel[1])   n_rel++;
        end
        checks++; if (n_press != 1) begin errors++; $display("FAIL long_press_count: got %0d want 1", n_press); end
        checks++; if (n_long != 1) begin errors++; $display("FAIL long_count: got %0d want 1", n_long); end
        checks++; if (long_cyc - press_cyc != 80) begin errors++; $display("FAIL long_delay: got %0d want 80", long_cyc - press_cyc); end
        checks++; if (n_rel != 1) begin errors++; $display("FAIL long_release_count: got %0d want 1", n_rel); end
    endtask

    task automatic test_release_glitch();
        int press_cyc, long_cyc, n_long, n_rel;
        bit found;
        found = 0; press_cyc = 0; long_cyc = 0; n_long = 0; n_rel = 0;
        key[0] = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            @(negedge clk);
            if (dut_press[0]) begin found = 1; press_cyc = cyc; end
        end
        checks++; if (!found) begin errors++; $display("FAIL glitch_press_seen: got none want press within 60 cycles"); end
        for (int c = 0; c < 200; c++) begin
            if (c == 40) key[0] = 1'b1;
            if (c == 52) key[0] = 1'b0;
            if (c == 150) key[0] = 1'b1;
            @(negedge clk);
            checks++;
            if ({dut_level, dut_press, dut_rel, dut_long} !== {ms.level, ms.press, ms.rel, ms.lng}) begin
                errors++; $display("FAIL glitch_model: dut=%b model=%b", {dut_level, dut_press, dut_rel, dut_long}, {ms.level, ms.press, ms.rel, ms.lng});
            end
            if (dut_long[0]) begin n_long++; long_cyc = cyc; end
            if (dut_rel[0] && c < 150) n_rel++;
        end
        checks++; if (n_rel != 0) begin errors++; $display("FAIL glitch_no_release: got %0d want 0", n_rel); end
        checks++; if (n_long != 1) begin errors++; $display("FAIL glitch_long_count: got %0d want 1", n_long); end
        checks++; if ((long_cyc - press_cyc) < 90 || (long_cyc - press_cyc) > 100) begin
            errors++; $display("FAIL glitch_long_delay: got %0d want 90..100", long_cyc - press_cyc);
        end
        checks++; if (dut_level[0] !== 1'b0) begin errors++; $display("FAIL glitch_final_level: got %b want 0", dut_level[0]); end
    endtask

    task automatic test_simultaneous();
        int n_press, n_rel;
        n_press = 0; n_rel = 0;
        key = 2'b00;
        for (int c = 0; c < 120; c++) begin
            if (c == 60) key = 2'b11;
            @(negedge clk);
            checks++;
            if ({dut_level, dut_press, dut_rel, dut_long} !== {ms.level, ms.press, ms.rel, ms.lng}) begin
                errors++; $display("FAIL simul_model: dut=%b model=%b", {dut_level, dut_press, dut_rel, dut_long}, {ms.level, ms.press, ms.rel, ms.lng});
            end
            if (dut_press != 2'b00) begin
                n_press++;
                checks++; if (dut_press !== 2'b11) begin errors++; $display("FAIL simul_press: got %b want 11", dut_press); end
            end
            if (dut_rel != 2'b00) begin
                n_rel++;
                checks++; if (dut_rel !== 2'b11) begin errors++; $display("FAIL simul_release: got %b want 11", dut_rel); end
            end
        end
        checks++; if (n_press != 1) begin errors++; $display("FAIL simul_press_count: got %0d want 1", n_press); end
        checks++; if (n_rel != 1) begin errors++; $display("FAIL simul_release_count: got %0d want 1", n_rel); end
    endtask

    task automatic test_reset_mid_held();
        bit found;
        int n_rel;
        found = 0; n_rel = 0;
        key[0] = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            @(negedge clk);
            if (dut_level[0]) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL midrst_held_reached: got level 0 want 1 within 60 cycles"); end
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (dut_level !== 2'b00) begin errors++; $display("FAIL midrst_async_level: got %b want 00", dut_level); end
        repeat (3) begin
            @(negedge clk);
            if (dut_rel != 2'b00) n_rel++;
        end
        key = 2'b11;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (dut_rel != 2'b00) n_rel++;
            checks++;
            if ({dut_level, dut_press, dut_rel, dut_long} !== {ms.level, ms.press, ms.rel, ms.lng}) begin
                errors++; $display("FAIL midrst_model: dut=%b model=%b", {dut_level, dut_press, dut_rel, dut_long}, {ms.level, ms.press, ms.rel, ms.lng});
            end
        end
        checks++; if (n_rel != 0) begin errors++; $display("FAIL midrst_no_release: got %0d want 0", n_rel); end
    endtask

    task automatic test_random();
        int remain [NK];
        for (int i = 0; i < NK; i++) remain[i] = 0;
        repeat (1500) begin
            for (int i = 0; i < NK; i++) begin
                if (remain[i] == 0) begin
                    key[i] = 1'($urandom_range(0, 1));
                    remain[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 150)) : int'($urandom_range(1, 30));
                end
                remain[i]--;
            end
            @(negedge clk);
            checks++;
            if ({dut_level, dut_press, dut_rel, dut_long} !== {ms.level, ms.press, ms.rel, ms.lng}) begin
                errors++; $display("FAIL random_model: dut=%b model=%b", {dut_level, dut_press, dut_rel, dut_long}, {ms.level, ms.press, ms.rel, ms.lng});
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_release_glitch();
        test_simultaneous();
        test_reset_mid_held();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
